// File: rtl/guess_key_entry.sv
// Digit-entry front end for the number-guessing game: conditions five raw buttons,
// buffers digits 1..4 and hands each completed number to the game core.
module guess_key_entry #(
  parameter int MAX_DIGITS = 5,
  parameter int DEBOUNCE   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    I1,
  input  logic                    I2,
  input  logic                    I3,
  input  logic                    I4,
  input  logic                    enter,
  input  logic                    num_ready,
  output logic                    num_valid,
  output logic [3*MAX_DIGITS-1:0] num_digits,
  output logic [2:0]              num_len,
  output logic                    num_ovf,
  output logic [2:0]              digit_count,
  output logic [3:0]              last_key,
  output logic                    key_err,
  output logic                    dbg_state
);

  localparam int               CW      = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CW-1:0]    CNT_MAX = CW'(DEBOUNCE - 1);
  localparam logic [2:0]       MAXD    = 3'(MAX_DIGITS);

  typedef enum logic {COLLECT = 1'b0, PENDING = 1'b1} state_t;

  // Bit order of the conditioned vector: [0]=I1 .. [3]=I4, [4]=enter.
  logic [4:0]    raw;
  logic [4:0]    sync1_q, sync2_q, deb_q, deb_prev_q;
  logic [CW-1:0] deb_cnt_q [5];
  logic [4:0]    ev;

  assign raw = {enter, I4, I3, I2, I1};

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      for (int i = 0; i < 5; i++) deb_cnt_q[i] <= '0;
    end else begin
      sync1_q    <= raw;
      sync2_q    <= sync1_q;
      deb_prev_q <= deb_q;
      for (int i = 0; i < 5; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          deb_cnt_q[i] <= '0;
        end else if (deb_cnt_q[i] == CNT_MAX) begin
          deb_q[i]     <= sync2_q[i];
          deb_cnt_q[i] <= '0;
        end else begin
          deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Press events are one cycle wide: debounced state rose on the previous edge.
  assign ev = deb_q & ~deb_prev_q;

  state_t                  state_q, state_d;
  logic [3*MAX_DIGITS-1:0] buf_q, buf_d, out_digits_q, out_digits_d;
  logic [2:0]              dcnt_q, dcnt_d, out_len_q, out_len_d;
  logic                    ovf_q, ovf_d, out_ovf_q, out_ovf_d;
  logic [3:0]              last_key_q, last_key_d;
  logic                    key_err_q, key_err_d;
  logic                    multi_ev, any_ev;
  logic [2:0]              dval;

  assign multi_ev = |(ev & (ev - 5'd1));
  assign any_ev   = |ev;
  assign dval     = ev[0] ? 3'd1 : ev[1] ? 3'd2 : ev[2] ? 3'd3 : 3'd4;

  // Handshake: num_valid rises when a number is loaded and stays high, with
  // num_digits/num_len/num_ovf frozen, until the first edge where num_ready is
  // also high; that edge is the transfer and num_valid falls on it.
  always_comb begin
    state_d      = state_q;
    buf_d        = buf_q;
    dcnt_d       = dcnt_q;
    ovf_d        = ovf_q;
    out_digits_d = out_digits_q;
    out_len_d    = out_len_q;
    out_ovf_d    = out_ovf_q;
    last_key_d   = last_key_q;
    key_err_d    = 1'b0;
    case (state_q)
      COLLECT: begin
        if (multi_ev) begin
          key_err_d = 1'b1;
        end else if (ev[4]) begin
          if (dcnt_q != 3'd0) begin
            out_digits_d = buf_q;
            out_len_d    = dcnt_q;
            out_ovf_d    = ovf_q;
            buf_d        = '0;
            dcnt_d       = 3'd0;
            ovf_d        = 1'b0;
            state_d      = PENDING;
          end
        end else if (any_ev) begin
          last_key_d = ev[3:0];
          if (dcnt_q < MAXD) begin
            for (int s = 0; s < MAX_DIGITS; s++) begin
              if (dcnt_q == 3'(s)) buf_d[3*(MAX_DIGITS-1-s) +: 3] = dval;
            end
            dcnt_d = dcnt_q + 3'd1;
          end else begin
            ovf_d     = 1'b1;
            key_err_d = 1'b1;
          end
        end
      end
      PENDING: begin
        if (num_ready) state_d = COLLECT;
        if (any_ev)    key_err_d = 1'b1;
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= COLLECT;
      buf_q        <= '0;
      dcnt_q       <= '0;
      ovf_q        <= 1'b0;
      out_digits_q <= '0;
      out_len_q    <= '0;
      out_ovf_q    <= 1'b0;
      last_key_q   <= '0;
      key_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      buf_q        <= buf_d;
      dcnt_q       <= dcnt_d;
      ovf_q        <= ovf_d;
      out_digits_q <= out_digits_d;
      out_len_q    <= out_len_d;
      out_ovf_q    <= out_ovf_d;
      last_key_q   <= last_key_d;
      key_err_q    <= key_err_d;
    end
  end

  assign num_valid   = (state_q == PENDING);
  assign num_digits  = out_digits_q;
  assign num_len     = out_len_q;
  assign num_ovf     = out_ovf_q;
  assign digit_count = dcnt_q;
  assign last_key    = last_key_q;
  assign key_err     = key_err_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_guess_key_entry.sv
// Directed bench for guess_key_entry: a DEBOUNCE=4 instance for the main
// sequence and a DEBOUNCE=1 instance for the short-latency case.
module tb_guess_key_entry;

  localparam int DB    = 4;
  localparam int MAXD  = 5;
  localparam int K_I1  = 0;
  localparam int K_I2  = 1;
  localparam int K_I3  = 2;
  localparam int K_I4  = 3;
  localparam int K_EN  = 4;

  logic clk = 1'b0;
  logic reset;
  logic I1, I2, I3, I4, enter, num_ready;
  logic num_valid, num_ovf, key_err, dbg_state;
  logic [3*MAXD-1:0] num_digits;
  logic [2:0] num_len, digit_count;
  logic [3:0] last_key;

  logic d1_I1, d1_I2, d1_I3, d1_I4, d1_enter, d1_ready;
  logic d1_valid, d1_ovf, d1_err, d1_state;
  logic [3*MAXD-1:0] d1_digits;
  logic [2:0] d1_len, d1_count;
  logic [3:0] d1_last;

  int vectors = 0;
  int miscompares = 0;
  int xfer_cnt = 0;
  logic [18:0] exp_q[$];
  logic [18:0] exp_item;

  // clock / reset
  always #5 clk = ~clk;

  guess_key_entry #(.MAX_DIGITS(MAXD), .DEBOUNCE(DB)) u_dut (
    .clk(clk), .reset(reset), .I1(I1), .I2(I2), .I3(I3), .I4(I4), .enter(enter),
    .num_ready(num_ready), .num_valid(num_valid), .num_digits(num_digits),
    .num_len(num_len), .num_ovf(num_ovf), .digit_count(digit_count),
    .last_key(last_key), .key_err(key_err), .dbg_state(dbg_state)
  );

  guess_key_entry #(.MAX_DIGITS(MAXD), .DEBOUNCE(1)) u_dut_d1 (
    .clk(clk), .reset(reset), .I1(d1_I1), .I2(d1_I2), .I3(d1_I3), .I4(d1_I4),
    .enter(d1_enter), .num_ready(d1_ready), .num_valid(d1_valid),
    .num_digits(d1_digits), .num_len(d1_len), .num_ovf(d1_ovf),
    .digit_count(d1_count), .last_key(d1_last), .key_err(d1_err),
    .dbg_state(d1_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_key(input int k, input logic v);
    case (k)
      K_I1:    I1 = v;
      K_I2:    I2 = v;
      K_I3:    I3 = v;
      K_I4:    I4 = v;
      default: enter = v;
    endcase
  endtask

  // Leaves the key held just after the edge where its event takes effect.
  task automatic key_down(input int k);
    set_key(k, 1'b1);
    repeat (DB + 3) tick();
  endtask

  task automatic key_up(input int k);
    tick();
    set_key(k, 1'b0);
    repeat (DB + 4) tick();
  endtask

  task automatic press(input int k);
    key_down(k);
    key_up(k);
  endtask

  // scoreboard: a transfer happens at the next edge when valid && ready here
  always @(negedge clk) begin
    if (!reset && num_valid && num_ready) begin
      xfer_cnt++;
      if (exp_q.size() == 0) begin
        check("xfer_unexpected", 32'(num_digits), 32'hFFFF_FFFF);
      end else begin
        exp_item = exp_q.pop_front();
        check("xfer_number", 32'({num_ovf, num_len, num_digits}), 32'(exp_item));
      end
    end
  end

  initial begin
    reset = 1'b1;
    {I1, I2, I3, I4, enter} = '0;
    {d1_I1, d1_I2, d1_I3, d1_I4, d1_enter} = '0;
    num_ready = 1'b1;
    d1_ready = 1'b0;
    repeat (3) tick();
    check("rst_valid", 32'(num_valid), 32'd0);
    check("rst_digits", 32'(num_digits), 32'd0);
    check("rst_len_ovf", 32'({num_len, num_ovf}), 32'd0);
    check("rst_count_last_err", 32'({digit_count, last_key, key_err}), 32'd0);
    reset = 1'b0;
    tick();

    // 1,2,3,4 + enter with ready held high
    exp_q.push_back({1'b0, 3'd4, 15'b001_010_011_100_000});
    press(K_I1);
    press(K_I2);
    press(K_I3);
    check("t1_count3", 32'(digit_count), 32'd3);
    check("t1_last_i3", 32'(last_key), 32'b0100);
    press(K_I4);
    check("t1_count4", 32'(digit_count), 32'd4);
    press(K_EN);
    check("t1_xfers", 32'(xfer_cnt), 32'd1);
    check("t1_valid_low", 32'(num_valid), 32'd0);
    check("t1_count_clear", 32'(digit_count), 32'd0);
    check("t1_len_kept", 32'(num_len), 32'd4);
    check("t1_digits_kept", 32'(num_digits), 32'(15'b001_010_011_100_000));

    // 4,2,4,1,3 + enter with ready low: number is held
    num_ready = 1'b0;
    press(K_I4);
    press(K_I2);
    press(K_I4);
    press(K_I1);
    press(K_I3);
    press(K_EN);
    check("t2_valid_held", 32'(num_valid), 32'd1);
    check("t2_len", 32'(num_len), 32'd5);
    check("t2_digits", 32'(num_digits), 32'(15'b100_010_100_001_011));
    check("t2_ovf", 32'(num_ovf), 32'd0);
    key_down(K_I1);
    check("t2_pending_err", 32'(key_err), 32'd1);
    check("t2_pending_count", 32'(digit_count), 32'd0);
    check("t2_pending_valid", 32'(num_valid), 32'd1);
    key_up(K_I1);
    check("t2_err_pulse_end", 32'(key_err), 32'd0);
    check("t2_digits_stable", 32'(num_digits), 32'(15'b100_010_100_001_011));
    exp_q.push_back({1'b0, 3'd5, 15'b100_010_100_001_011});
    num_ready = 1'b1;
    tick();
    tick();
    check("t2_xfers", 32'(xfer_cnt), 32'd2);
    check("t2_valid_low", 32'(num_valid), 32'd0);
    exp_q.push_back({1'b0, 3'd4, 15'b100_010_100_001_000});
    press(K_I4);
    press(K_I2);
    press(K_I4);
    press(K_I1);
    press(K_EN);
    check("t2_next_xfers", 32'(xfer_cnt), 32'd3);

    // overflow: sixth digit dropped
    press(K_I1);
    press(K_I4);
    press(K_I3);
    press(K_I2);
    press(K_I1);
    key_down(K_I2);
    check("t3_ovf_err", 32'(key_err), 32'd1);
    check("t3_ovf_count", 32'(digit_count), 32'd5);
    check("t3_ovf_last", 32'(last_key), 32'b0010);
    key_up(K_I2);
    exp_q.push_back({1'b1, 3'd5, 15'b001_100_011_010_001});
    press(K_EN);
    exp_q.push_back({1'b0, 3'd1, 15'b011_000_000_000_000});
    press(K_I3);
    press(K_EN);
    check("t3_xfers", 32'(xfer_cnt), 32'd5);

    // enter on an empty buffer
    key_down(K_EN);
    check("t4_empty_err", 32'(key_err), 32'd0);
    check("t4_empty_valid", 32'(num_valid), 32'd0);
    key_up(K_EN);
    check("t4_empty_xfers", 32'(xfer_cnt), 32'd5);

    // glitch of three synchronized cycles
    I2 = 1'b1;
    repeat (3) tick();
    I2 = 1'b0;
    repeat (10) tick();
    check("t4_glitch_count", 32'(digit_count), 32'd0);
    check("t4_glitch_last", 32'(last_key), 32'b0100);

    // held key: count updates exactly at edge DB+2, only once
    I2 = 1'b1;
    repeat (DB + 2) tick();
    check("t4_edge5_count", 32'(digit_count), 32'd0);
    tick();
    check("t4_edge6_count", 32'(digit_count), 32'd1);
    check("t4_edge6_last", 32'(last_key), 32'b0010);
    repeat (33) tick();
    check("t4_held_once", 32'(digit_count), 32'd1);
    I2 = 1'b0;
    repeat (DB + 4) tick();

    // simultaneous I1 and I3
    I1 = 1'b1;
    I3 = 1'b1;
    repeat (DB + 3) tick();
    check("t5_dual_err", 32'(key_err), 32'd1);
    check("t5_dual_count", 32'(digit_count), 32'd1);
    check("t5_dual_last", 32'(last_key), 32'b0010);
    tick();
    I1 = 1'b0;
    I3 = 1'b0;
    repeat (DB + 4) tick();

    // reset while pending
    num_ready = 1'b0;
    press(K_EN);
    check("t5_pend_valid", 32'(num_valid), 32'd1);
    check("t5_pend_len", 32'(num_len), 32'd1);
    reset = 1'b1;
    tick();
    check("t5_rst_valid", 32'(num_valid), 32'd0);
    check("t5_rst_digits", 32'(num_digits), 32'd0);
    check("t5_rst_len_ovf", 32'({num_len, num_ovf}), 32'd0);
    check("t5_rst_count_last", 32'({digit_count, last_key}), 32'd0);
    reset = 1'b0;
    tick();

    // DEBOUNCE=1 instance: event lands at edge 3
    d1_I4 = 1'b1;
    repeat (3) tick();
    check("d1_edge2_count", 32'(d1_count), 32'd0);
    tick();
    check("d1_edge3_count", 32'(d1_count), 32'd1);
    check("d1_edge3_last", 32'(d1_last), 32'b1000);
    d1_I4 = 1'b0;
    repeat (4) tick();

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/guess_key_entry.md
Name: guess_key_entry

Overview:
- Front-end digit-entry stage for the number-guessing game. It sits directly upstream of the game core that produces win/lose/equal/bigger/smaller.
- Conditions the raw buttons I1..I4 and enter: 2-FF synchronizer, debounce, rising-edge detection.
- Collects a sequence of digits 1..4 into a buffer of up to MAX_DIGITS digits.
- On enter, hands the completed number to the game core over a valid/ready handshake. The first number entered after reset is the secret; later numbers are guesses. The core makes that distinction, not this block.

Parameters:
- MAX_DIGITS, 5, buffer capacity in digits; legal range 1..7.
- DEBOUNCE, 4, consecutive stable synchronized cycles required to change a debounced key state; legal minimum 1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high; one clock, one reset domain.
- I1, I2, I3, I4  in  1 each  raw buttons for digits 1, 2, 3, 4; asynchronous to clk.
- enter  in  1  raw submit button; asynchronous to clk.
- num_ready  in  1  game core can accept a number.
- num_valid  out  1  submitted number is available.
- num_digits  out  3*MAX_DIGITS  packed digits, 3 bits each; first-entered digit in the MSB slot; unused slots are 0.
- num_len  out  3  number of valid digits, 1..MAX_DIGITS.
- num_ovf  out  1  digits were dropped from this number.
- digit_count  out  3  live count of buffered digits.
- last_key  out  4  one-hot of the last accepted digit key (bit0 = I1, bit3 = I4); drives the nums display.
- key_err  out  1  one-cycle pulse when an event is rejected.

Behaviour:
- Reset values: all outputs 0, buffer cleared, state COLLECT, all debounced keys released, all debounce counters 0.
- Reset mid-operation discards everything, including a pending num_valid.
- A key held through reset registers as a new press DEBOUNCE+2 edges after reset deasserts.
- Conditioning, per input:
  - Two-flop synchronizer.
  - The debounced state flips once the synchronized value has differed from it for DEBOUNCE consecutive cycles; the counter clears whenever the values agree.
  - A press event is the debounced 0->1 transition.
- Latency: the raw input is first sampled high at edge 0 and held high. The debounced state rises at edge DEBOUNCE+1. The event takes effect, and digit_count and last_key update, at edge DEBOUNCE+2.
- Glitches shorter than DEBOUNCE synchronized cycles produce no event.
- A held key produces exactly one event; the key must be debounced-released before it can fire again.
- Per-cycle arbitration counts events across all five inputs:
  - Exactly one event: processed.
  - Two or more events in the same cycle: all are discarded, key_err pulses, and state and buffer are unchanged.
- State COLLECT:
  - Digit event with digit_count < MAX_DIGITS: the 3-bit digit value (1..4) is written to slot digit_count; digit_count increments; last_key is set.
  - Digit event with digit_count == MAX_DIGITS: the digit is dropped, the sticky overflow bit is set, key_err pulses, and last_key is still updated.
  - Enter event with digit_count == 0: ignored, no key_err.
  - Enter event with digit_count > 0, at that edge:
    - num_digits, num_len and num_ovf load from the buffer and overflow bit.
    - num_valid goes to 1.
    - The buffer, digit_count and overflow bit clear.
    - State moves to PENDING.
- State PENDING:
  - num_valid, num_digits, num_len and num_ovf are held stable.
  - Transfer occurs at the first edge with num_valid && num_ready. At that edge num_valid goes to 0 and state returns to COLLECT. num_digits, num_len and num_ovf keep their values until the next load.
  - Digit and enter events arriving in PENDING are discarded and key_err pulses. Events in the transfer cycle itself are also discarded.
- num_ready high while in COLLECT has no effect.
- last_key is held until the next accepted or overflowed digit, or reset.

Test Plan:
- DEBOUNCE=1, MAX_DIGITS=5, num_ready=1. Press 1,2,3,4 then enter -> one num_valid pulse; num_len=4; num_digits=001_010_011_100_000; num_ovf=0; digit_count returns to 0.
- Press 4,2,4,1,3 then enter, num_ready=0 for 10 cycles -> num_valid held high with num_len=5 and num_digits=100_010_100_001_011. Presses during the wait pulse key_err. Raising num_ready gives a single transfer; the next entry 4,2,4,1 yields num_len=4.
- Press 1,4,3,2,1,2 then enter -> the 6th digit is dropped with a key_err pulse; num_len=5, num_digits=001_100_011_010_001, num_ovf=1. The next number has num_ovf=0.
- DEBOUNCE=4: I2 high for 3 synchronized cycles -> no event. I2 held high for 40 cycles -> exactly one digit, digit_count updates at edge 6. Enter with an empty buffer -> nothing happens.
- I1 and I3 rising in the same cycle -> key_err pulse, digit_count unchanged. Assert reset while PENDING -> num_valid=0 next edge and all outputs zero.
